// File: rtl/preamble_peak_tracker_pkg.sv
// Shared types and field layout for the preamble peak tracker.
// Detection state, metric width and event packing offsets.
package preamble_peak_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLDOFF
  } state_e;

  localparam int EV_OFFSET_LSB = 0;

  function automatic int metric_width(input int mag_w);
    return mag_w + 2;
  endfunction

  function automatic int ev_metric_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int ev_phase_lsb(input int mag_w, input int cnt_w);
    return mag_w + cnt_w;
  endfunction

endpackage

// File: rtl/preamble_metric_calc.sv
// Stage-1 arithmetic: signed D metric, trigger and phase scaling.
// Purely combinational; the top registers the results.
module preamble_metric_calc
  import preamble_peak_tracker_pkg::*;
#(
  parameter int MAG_WIDTH  = 16,
  parameter int WINDOW_LEN = 64
) (
  input  logic [MAG_WIDTH-1:0]        mag_i,
  input  logic [MAG_WIDTH-1:0]        power_i,
  input  logic [MAG_WIDTH-1:0]        phase_i,
  input  logic [3:0]                  k_i,
  output logic signed [MAG_WIDTH+1:0] metric_o,
  output logic                        trigger_o,
  output logic signed [MAG_WIDTH-1:0] phase_o
);

  localparam int MW = metric_width(MAG_WIDTH);
  localparam int SH = $clog2(WINDOW_LEN);

  logic [MW-1:0] mag_x;
  logic [MW-1:0] pwr_x;
  logic [MW-1:0] pwr_s;

  assign mag_x = {2'b00, mag_i};
  assign pwr_x = {2'b00, power_i};
  assign pwr_s = pwr_x >> k_i;

  assign metric_o = signed'(mag_x - (pwr_x - pwr_s));

  // k = 0 would make the threshold zero, so it means "never"
  assign trigger_o = (k_i != 4'd0)
                   && !metric_o[MW-1]
                   && (metric_o != '0);

  assign phase_o = $signed(phase_i) >>> SH;

endmodule

// File: rtl/preamble_peak_tracker.sv
// Preamble peak tracker: metric stage, run/peak/holdoff FSM, event register.
// Optional stats outputs under PREAMBLE_PEAK_TRACKER_STATS_EN.
module preamble_peak_tracker
  import preamble_peak_tracker_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAG_WIDTH  = 16,
  parameter int WINDOW_LEN = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cfg_enable,
  input  logic [3:0]                       cfg_thresh_shift,
  input  logic [7:0]                       cfg_min_run,
  input  logic [CNT_WIDTH-1:0]             cfg_holdoff,
  input  logic [MAG_WIDTH-1:0]             i_mag,
  input  logic [MAG_WIDTH-1:0]             i_phase,
  input  logic [MAG_WIDTH-1:0]             i_power,
  input  logic [WIDTH-1:0]                 i_samples_tdata,
  input  logic                             i_tvalid,
  output logic                             i_tready,
  output logic [WIDTH-1:0]                 o_samples_tdata,
  output logic                             o_samples_tlast,
  output logic                             o_samples_tvalid,
  input  logic                             o_samples_tready,
  output logic [2*MAG_WIDTH+CNT_WIDTH-1:0] o_event_tdata,
  output logic                             o_event_tvalid,
`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
  output logic [31:0]                      stat_detect_cnt,
  output logic [31:0]                      stat_drop_cnt,
`endif
  input  logic                             o_event_tready
);

  localparam int MW     = metric_width(MAG_WIDTH);
  localparam int EW     = 2*MAG_WIDTH + CNT_WIDTH;
  localparam int EV_MET = ev_metric_lsb(CNT_WIDTH);
  localparam int EV_PH  = ev_phase_lsb(MAG_WIDTH, CNT_WIDTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] x
  );
    return (x == '1) ? x : x + CNT_WIDTH'(1);
  endfunction

  logic signed [MW-1:0]        c_metric;
  logic                        c_trig;
  logic signed [MAG_WIDTH-1:0] c_phase;

  preamble_metric_calc #(
    .MAG_WIDTH  (MAG_WIDTH),
    .WINDOW_LEN (WINDOW_LEN)
  ) u_calc (
    .mag_i     (i_mag),
    .power_i   (i_power),
    .phase_i   (i_phase),
    .k_i       (cfg_thresh_shift),
    .metric_o  (c_metric),
    .trigger_o (c_trig),
    .phase_o   (c_phase)
  );

  logic                 s1_valid_q, s1_valid_d;
  logic signed [MW-1:0] s1_metric_q;
  logic                 s1_trig_q;
  logic [MAG_WIDTH-1:0] s1_phase_q;
  logic [WIDTH-1:0]     s1_data_q;

  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;

  logic s2_ready;
  logic s1_load;
  logic adv;

  assign s2_ready = !out_valid_q || o_samples_tready;
  assign i_tready = !s1_valid_q || s2_ready;
  assign s1_load  = i_tvalid && i_tready;
  assign adv      = s1_valid_q && s2_ready;

  assign s1_valid_d = i_tready ? i_tvalid : s1_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_metric_q <= '0;
      s1_trig_q   <= 1'b0;
      s1_phase_q  <= '0;
      s1_data_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_metric_q <= c_metric;
        s1_trig_q   <= c_trig;
        s1_phase_q  <= c_phase;
        s1_data_q   <= i_samples_tdata;
      end
    end
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] run_q, run_d;
  logic [CNT_WIDTH-1:0] off_q, off_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0] hcfg_q, hcfg_d;
  logic [7:0]           minrun_q, minrun_d;
  logic signed [MW-1:0] peak_q, peak_d;
  logic [MAG_WIDTH-1:0] pph_q, pph_d;
  logic                 declare;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    off_d    = off_q;
    hold_d   = hold_q;
    hcfg_d   = hcfg_q;
    minrun_d = minrun_q;
    peak_d   = peak_q;
    pph_d    = pph_q;
    declare  = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else if (adv) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s1_trig_q) begin
            state_d  = ST_RUN;
            run_d    = CNT_WIDTH'(1);
            off_d    = '0;
            peak_d   = s1_metric_q;
            pph_d    = s1_phase_q;
            minrun_d = cfg_min_run;
            hcfg_d   = cfg_holdoff;
          end
        end
        ST_RUN: begin
          if (s1_trig_q) begin
            run_d = sat_inc(run_q);
            // strict compare: ties keep the earliest peak
            if (s1_metric_q > peak_q) begin
              peak_d = s1_metric_q;
              pph_d  = s1_phase_q;
              off_d  = '0;
            end else begin
              off_d = sat_inc(off_q);
            end
          end else if (run_q >= CNT_WIDTH'(minrun_q)) begin
            declare = 1'b1;
            hold_d  = hcfg_q;
            state_d = ST_HOLDOFF;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_q == '0) state_d = ST_IDLE;
          else hold_d = hold_q - CNT_WIDTH'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      out_last_d  = declare;
      if (adv) out_data_d = s1_data_q;
    end
  end

  logic          ev_valid_q, ev_valid_d;
  logic [EW-1:0] ev_data_q, ev_data_d;
  logic [EW-1:0] ev_new;
  logic          ev_busy;

  assign ev_busy = ev_valid_q && !o_event_tready;

  always_comb begin
    ev_new = '0;
    ev_new[EV_PH +: MAG_WIDTH]          = pph_q;
    ev_new[EV_MET +: MAG_WIDTH]         = peak_q[MAG_WIDTH-1:0];
    ev_new[EV_OFFSET_LSB +: CNT_WIDTH]  = sat_inc(off_q);
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_data_d  = ev_data_q;
    if (declare && !ev_busy) begin
      ev_valid_d = 1'b1;
      ev_data_d  = ev_new;
    end else if (ev_valid_q && o_event_tready) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      off_q       <= '0;
      hold_q      <= '0;
      hcfg_q      <= '0;
      minrun_q    <= '0;
      peak_q      <= '0;
      pph_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      ev_valid_q  <= 1'b0;
      ev_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      off_q       <= off_d;
      hold_q      <= hold_d;
      hcfg_q      <= hcfg_d;
      minrun_q    <= minrun_d;
      peak_q      <= peak_d;
      pph_q       <= pph_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      ev_valid_q  <= ev_valid_d;
      ev_data_q   <= ev_data_d;
    end
  end

  assign o_samples_tvalid = out_valid_q;
  assign o_samples_tlast  = out_last_q;
  assign o_samples_tdata  = out_data_q;
  assign o_event_tvalid   = ev_valid_q;
  assign o_event_tdata    = ev_data_q;

`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
  logic [31:0] det_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (declare) det_cnt_q <= det_cnt_q + 32'd1;
      if (declare && ev_busy) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_detect_cnt = det_cnt_q;
  assign stat_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_preamble_peak_tracker.sv
// Directed bench for preamble_peak_tracker with sample/event scoreboards.
// Stats checks compile in when PREAMBLE_PEAK_TRACKER_STATS_EN is defined.
module tb_preamble_peak_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_enable;
  logic [3:0]  cfg_thresh_shift;
  logic [7:0]  cfg_min_run;
  logic [15:0] cfg_holdoff;
  logic [15:0] i_mag;
  logic [15:0] i_phase;
  logic [15:0] i_power;
  logic [31:0] i_samples_tdata;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_samples_tdata;
  logic        o_samples_tlast;
  logic        o_samples_tvalid;
  logic        o_samples_tready;
  logic [47:0] o_event_tdata;
  logic        o_event_tvalid;
  logic        o_event_tready;
`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
  logic [31:0] stat_detect_cnt;
  logic [31:0] stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  preamble_peak_tracker dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_enable       (cfg_enable),
    .cfg_thresh_shift (cfg_thresh_shift),
    .cfg_min_run      (cfg_min_run),
    .cfg_holdoff      (cfg_holdoff),
    .i_mag            (i_mag),
    .i_phase          (i_phase),
    .i_power          (i_power),
    .i_samples_tdata  (i_samples_tdata),
    .i_tvalid         (i_tvalid),
    .i_tready         (i_tready),
    .o_samples_tdata  (o_samples_tdata),
    .o_samples_tlast  (o_samples_tlast),
    .o_samples_tvalid (o_samples_tvalid),
    .o_samples_tready (o_samples_tready),
    .o_event_tdata    (o_event_tdata),
    .o_event_tvalid   (o_event_tvalid),
`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
    .stat_detect_cnt  (stat_detect_cnt),
    .stat_drop_cnt    (stat_drop_cnt),
`endif
    .o_event_tready   (o_event_tready)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [32:0] exp_q[$];
  logic [47:0] ev_q[$];
  logic        stall_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [15:0] mag, input logic [15:0] ph,
                      input logic last);
    logic        rdy;
    int          n;
    logic [31:0] d;
    d = $urandom();
    i_mag = mag;
    i_phase = ph;
    i_samples_tdata = d;
    i_tvalid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = i_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 64'(rdy), 64'd1);
    exp_q.push_back({last, d});
    i_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'd100, 16'd0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    logic [47:0] ev;
    if (reset_n && o_samples_tvalid && o_samples_tready) begin
      chk("sample_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sample", {31'd0, o_samples_tlast, o_samples_tdata}, 64'(e));
      end
    end
    if (reset_n && o_event_tvalid && o_event_tready) begin
      chk("event_pending", 64'(ev_q.size() != 0), 64'd1);
      if (ev_q.size() != 0) begin
        ev = ev_q.pop_front();
        chk("event", 64'(o_event_tdata), 64'(ev));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_en) o_samples_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [31:0] d;
    reset_n = 1'b0;
    cfg_enable = 1'b1;
    cfg_thresh_shift = 4'd2;
    cfg_min_run = 8'd3;
    cfg_holdoff = 16'd0;
    i_mag = '0;
    i_phase = '0;
    i_power = '0;
    i_samples_tdata = '0;
    i_tvalid = 1'b0;
    o_samples_tready = 1'b1;
    o_event_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(o_samples_tvalid), 64'd0);
    chk("rst_tlast", 64'(o_samples_tlast), 64'd0);
    chk("rst_evvalid", 64'(o_event_tvalid), 64'd0);
`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
    chk("rst_stat_det", 64'(stat_detect_cnt), 64'd0);
    chk("rst_stat_drop", 64'(stat_drop_cnt), 64'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    d = 32'hCAFE_0001;
    i_samples_tdata = d;
    i_tvalid = 1'b1;
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    exp_q.push_back({1'b0, d});
    chk("lat_cycle1", 64'(o_samples_tvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", {31'd0, o_samples_tvalid, o_samples_tdata},
        {31'd0, 1'b1, d});
    drain();

    i_power = 16'd1000;
    for (int i = 0; i < 5; i++) send(16'd700, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b0);

    ev_q.push_back({16'hFFF0, 16'd150, 16'd3});
    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'hFC18, 1'b0);
    send(16'd850, 16'd0, 1'b0);
    send(16'd760, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b1);
    idle(2);
    drain();

    cfg_min_run = 8'd5;
    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'hFC18, 1'b0);
    send(16'd850, 16'd0, 1'b0);
    send(16'd760, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b0);
    cfg_min_run = 8'd1;
    ev_q.push_back({16'd4, 16'd50, 16'd1});
    send(16'd800, 16'd256, 1'b0);
    send(16'd100, 16'd0, 1'b1);
    idle(2);
    drain();

    cfg_thresh_shift = 4'd0;
    send(16'd800, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b0);
    cfg_thresh_shift = 4'd2;
    idle(1);

    cfg_holdoff = 16'd10;
    cfg_min_run = 8'd2;
    ev_q.push_back({16'd10, 16'd150, 16'd1});
    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'd640, 1'b0);
    send(16'd100, 16'd0, 1'b1);
    idle(3);
    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'd640, 1'b0);
    send(16'd100, 16'd0, 1'b0);
    cfg_holdoff = 16'd0;
    idle(8);
    drain();

    cfg_enable = 1'b0;
    cfg_min_run = 8'd1;
    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b0);
    cfg_enable = 1'b1;
    idle(1);
    drain();

    stall_en = 1'b1;
    for (int i = 0; i < 40; i++) send(16'(i * 7), 16'd0, 1'b0);
    drain();
    stall_en = 1'b0;
    @(posedge clk);
    #2;
    o_samples_tready = 1'b1;
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    send(16'd800, 16'd0, 1'b0);
    send(16'd900, 16'd0, 1'b0);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_tvalid", 64'(o_samples_tvalid), 64'd0);
    chk("midrst_evvalid", 64'(o_event_tvalid), 64'd0);
    chk("midrst_tlast", 64'(o_samples_tlast), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(16'd100, 16'd0, 1'b0);
    idle(1);
    drain();

    o_event_tready = 1'b0;
    cfg_min_run = 8'd1;
    ev_q.push_back({16'hFFFF, 16'd50, 16'd1});
    send(16'd800, 16'hFFC0, 1'b0);
    send(16'd100, 16'd0, 1'b1);
    idle(2);
    send(16'd900, 16'd0, 1'b0);
    send(16'd100, 16'd0, 1'b1);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_valid", 64'(o_event_tvalid), 64'd1);
    chk("held_data", 64'(o_event_tdata), {16'd0, 16'hFFFF, 16'd50, 16'd1});
`ifdef PREAMBLE_PEAK_TRACKER_STATS_EN
    chk("stat_det", 64'(stat_detect_cnt), 64'd2);
    chk("stat_drop", 64'(stat_drop_cnt), 64'd1);
`endif
    o_event_tready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_ev", 64'(o_event_tvalid), 64'd0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("ev_q_empty", 64'(ev_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
